id_ex_latch: RTL and testbench

ID_EX_LATCH -- requirements
Module: id_ex_latch

---
 rtl/id_ex_latch.sv | 149 ++++++++++++++
 tb/tb_id_ex_latch.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional IDEX_PERF_EN adds saturating bubble/flush event counters.
module id_ex_latch #(
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          en,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [DW-1:0] id_pc,
    input  logic [DW-1:0] id_rdat1,
    input  logic [DW-1:0] id_rdat2,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic [4:0]    id_rd,
    input  logic          id_uses_rt,
    input  logic          id_regDst,
    input  logic          id_regWr,
    input  logic          id_memRead,
    input  logic          id_memWr,
    input  logic          id_aluSrc,
    input  logic [3:0]    id_aluop,
    output logic [DW-1:0] ex_pc,
    output logic [DW-1:0] ex_rdat1,
    output logic [DW-1:0] ex_rdat2,
    output logic [DW-1:0] ex_imm,
    output logic [4:0]    ex_rs,
    output logic [4:0]    ex_rt,
    output logic [4:0]    ex_rd,
    output logic [4:0]    ex_wsel,
    output logic          ex_regDst,
    output logic          ex_regWr,
    output logic          ex_memRead,
    output logic          ex_memWr,
    output logic          ex_aluSrc,
    output logic          ex_valid,
    output logic [3:0]    ex_aluop,
    output logic          lu_stall
`ifdef IDEX_PERF_EN
    ,
    output logic [15:0]   bubble_cnt,
    output logic [15:0]   flush_cnt
`endif
);

    typedef struct packed {
        logic [DW-1:0] pc;
        logic [DW-1:0] rdat1;
        logic [DW-1:0] rdat2;
        logic [DW-1:0] imm;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    rd;
        logic [4:0]    wsel;
        logic          regDst;
        logic          regWr;
        logic          memRead;
        logic          memWr;
        logic          aluSrc;
        logic          valid;
        logic [3:0]    aluop;
    } id_ex_t;

    id_ex_t ex_d, ex_q;
    logic   bubble;

    assign lu_stall = ex_q.valid & ex_q.memRead & (ex_q.rt != 5'd0)
                    & ((ex_q.rt == id_rs) | (id_uses_rt & (ex_q.rt == id_rt)))
                    & id_valid;

    assign bubble = flush | lu_stall | ~id_valid;

    always_comb begin
        ex_d = ex_q;
        if (en) begin
            if (bubble) begin
                ex_d = '0;
            end else begin
                ex_d.pc      = id_pc;
                ex_d.rdat1   = id_rdat1;
                ex_d.rdat2   = id_rdat2;
                ex_d.imm     = id_imm;
                ex_d.rs      = id_rs;
                ex_d.rt      = id_rt;
                ex_d.rd      = id_rd;
                ex_d.wsel    = id_regWr ? (id_regDst ? id_rd : id_rt) : 5'd0;
                ex_d.regDst  = id_regDst;
                ex_d.regWr   = id_regWr;
                ex_d.memRead = id_memRead;
                ex_d.memWr   = id_memWr;
                ex_d.aluSrc  = id_aluSrc;
                ex_d.valid   = 1'b1;
                ex_d.aluop   = id_aluop;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) ex_q <= '0;
        else       ex_q <= ex_d;
    end

    assign ex_pc      = ex_q.pc;
    assign ex_rdat1   = ex_q.rdat1;
    assign ex_rdat2   = ex_q.rdat2;
    assign ex_imm     = ex_q.imm;
    assign ex_rs      = ex_q.rs;
    assign ex_rt      = ex_q.rt;
    assign ex_rd      = ex_q.rd;
    assign ex_wsel    = ex_q.wsel;
    assign ex_regDst  = ex_q.regDst;
    assign ex_regWr   = ex_q.regWr;
    assign ex_memRead = ex_q.memRead;
    assign ex_memWr   = ex_q.memWr;
    assign ex_aluSrc  = ex_q.aluSrc;
    assign ex_valid   = ex_q.valid;
    assign ex_aluop   = ex_q.aluop;

`ifdef IDEX_PERF_EN
    logic [15:0] bubble_cnt_d, bubble_cnt_q;
    logic [15:0] flush_cnt_d, flush_cnt_q;

    // flush outranks lu_stall, so a combined event counts only as a flush
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (en && flush && flush_cnt_q != 16'hFFFF)
            flush_cnt_d = flush_cnt_q + 16'd1;
        if (en && !flush && lu_stall && bubble_cnt_q != 16'hFFFF)
            bubble_cnt_d = bubble_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_latch.sv
// Self-checking bench for id_ex_latch: reference model plus directed vectors.
module tb_id_ex_latch;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        en = 1'b1;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_pc = '0, id_rdat1 = '0, id_rdat2 = '0, id_imm = '0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic        id_uses_rt = 1'b0;
    logic        id_regDst = 1'b0, id_regWr = 1'b0, id_memRead = 1'b0;
    logic        id_memWr = 1'b0, id_aluSrc = 1'b0;
    logic [3:0]  id_aluop = '0;

    logic [31:0] ex_pc, ex_rdat1, ex_rdat2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_wsel;
    logic        ex_regDst, ex_regWr, ex_memRead, ex_memWr, ex_aluSrc;
    logic        ex_valid, lu_stall;
    logic [3:0]  ex_aluop;
`ifdef IDEX_PERF_EN
    logic [15:0] bubble_cnt, flush_cnt;
    int          m_bub = 0, m_fl = 0;
    logic [15:0] fl0, bub0;
`endif

    int checks = 0;
    int errors = 0;
    bit go = 1'b0;

    id_ex_latch #(.DW(32)) dut (
        .CLK(CLK), .nRST(nRST), .en(en), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_regDst(id_regDst), .id_regWr(id_regWr), .id_memRead(id_memRead),
        .id_memWr(id_memWr), .id_aluSrc(id_aluSrc), .id_aluop(id_aluop),
        .ex_pc(ex_pc), .ex_rdat1(ex_rdat1), .ex_rdat2(ex_rdat2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_wsel(ex_wsel),
        .ex_regDst(ex_regDst), .ex_regWr(ex_regWr), .ex_memRead(ex_memRead),
        .ex_memWr(ex_memWr), .ex_aluSrc(ex_aluSrc), .ex_valid(ex_valid),
        .ex_aluop(ex_aluop), .lu_stall(lu_stall)
`ifdef IDEX_PERF_EN
        , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // Expected EX contents as a flat list of field values
    int m_pc, m_r1, m_r2, m_imm, m_rs, m_rt, m_rd, m_wsel, m_op;
    int m_dst, m_wr, m_mr, m_mw, m_as, m_v;

    function automatic bit exp_stall();
        return m_v == 1 && m_mr == 1 && m_rt != 0 && id_valid
            && (m_rt == int'(id_rs) || (id_uses_rt && m_rt == int'(id_rt)));
    endfunction

    task automatic model_clear();
        {m_pc, m_r1, m_r2, m_imm, m_rs, m_rt, m_rd, m_wsel, m_op} = '0;
        {m_dst, m_wr, m_mr, m_mw, m_as, m_v} = '0;
    endtask

    initial model_clear();

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            model_clear();
`ifdef IDEX_PERF_EN
            m_bub = 0;
            m_fl = 0;
`endif
        end else if (en) begin
`ifdef IDEX_PERF_EN
            if (flush) m_fl = (m_fl < 65535) ? m_fl + 1 : 65535;
            else if (exp_stall()) m_bub = (m_bub < 65535) ? m_bub + 1 : 65535;
`endif
            if (flush || exp_stall() || !id_valid) begin
                model_clear();
            end else begin
                m_pc = id_pc; m_r1 = id_rdat1; m_r2 = id_rdat2; m_imm = id_imm;
                m_rs = id_rs; m_rt = id_rt; m_rd = id_rd; m_op = id_aluop;
                m_dst = id_regDst; m_wr = id_regWr; m_mr = id_memRead;
                m_mw = id_memWr; m_as = id_aluSrc; m_v = 1;
                if (!id_regWr) m_wsel = 0;
                else if (id_regDst) m_wsel = id_rd;
                else m_wsel = id_rt;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (go) begin
            chk("pc", ex_pc, m_pc);
            chk("rdat1", ex_rdat1, m_r1);
            chk("rdat2", ex_rdat2, m_r2);
            chk("imm", ex_imm, m_imm);
            chk("rs", 32'(ex_rs), m_rs);
            chk("rt", 32'(ex_rt), m_rt);
            chk("rd", 32'(ex_rd), m_rd);
            chk("wsel", 32'(ex_wsel), m_wsel);
            chk("aluop", 32'(ex_aluop), m_op);
            chk("ctl", {27'd0, ex_regDst, ex_regWr, ex_memRead, ex_memWr, ex_aluSrc},
                {27'd0, m_dst[0], m_wr[0], m_mr[0], m_mw[0], m_as[0]});
            chk("valid", 32'(ex_valid), m_v);
            chk("lu_stall", 32'(lu_stall), 32'(exp_stall()));
`ifdef IDEX_PERF_EN
            chk("bubble_cnt", 32'(bubble_cnt), m_bub);
            chk("flush_cnt", 32'(flush_cnt), m_fl);
`endif
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input bit v, input logic [4:0] rs, rt, rd, input bit ut,
                         input bit dst, wr, mr, input logic [31:0] pc);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = ut;
        id_regDst = dst; id_regWr = wr; id_memRead = mr;
        id_memWr = 1'b0; id_aluSrc = mr; id_aluop = pc[3:0];
        id_pc = pc; id_rdat1 = pc + 1; id_rdat2 = pc + 2; id_imm = pc + 3;
    endtask

    initial begin
        #1;
        repeat (2) step();
        chk("rst_valid", 32'(ex_valid), 0);
        chk("rst_stall", 32'(lu_stall), 0);
        nRST = 1'b1;
        go = 1'b1;

        // Destination selection
        drive(1, 3, 4, 5, 1, 1, 1, 0, 32'h100);
        step();
        chk("wsel_rd", 32'(ex_wsel), 5);
        chk("valid_cap", 32'(ex_valid), 1);
        chk("pc_cap", ex_pc, 32'h100);
        drive(1, 3, 4, 5, 1, 0, 1, 0, 32'h104);
        step();
        chk("wsel_rt", 32'(ex_wsel), 4);
        drive(1, 3, 4, 5, 1, 1, 0, 0, 32'h108);
        step();
        chk("wsel_nowr", 32'(ex_wsel), 0);

        // Asynchronous reset mid-cycle
        #2 nRST = 1'b0;
        #1;
        chk("arst_valid", 32'(ex_valid), 0);
        chk("arst_pc", ex_pc, 0);
        chk("arst_rs", 32'(ex_rs), 0);
        chk("arst_stall", 32'(lu_stall), 0);
        @(posedge CLK);
        #2 nRST = 1'b1;
        #1;

        // Load-use on rs
        drive(1, 1, 2, 0, 0, 0, 1, 1, 32'h200);
        step();
        drive(1, 2, 6, 7, 1, 1, 1, 0, 32'h204);
        #1 chk("lu_set", 32'(lu_stall), 1);
        step();
        chk("lu_bub_valid", 32'(ex_valid), 0);
        chk("lu_clr", 32'(lu_stall), 0);
        step();
        chk("lu_cap_valid", 32'(ex_valid), 1);
        chk("lu_cap_rd", 32'(ex_wsel), 7);

        // Stall held with en=0
        drive(1, 1, 2, 0, 0, 0, 1, 1, 32'h300);
        step();
        drive(1, 9, 2, 7, 1, 1, 1, 0, 32'h304);
        en = 1'b0;
        repeat (3) begin
            step();
            chk("hold_stall", 32'(lu_stall), 1);
            chk("hold_pc", ex_pc, 32'h300);
        end
        en = 1'b1;
        step();
        chk("hold_release", 32'(lu_stall), 0);

        // Hazard suppressed: ex_rt=0 and rt not used
        drive(1, 1, 0, 0, 0, 0, 1, 1, 32'h400);
        step();
        drive(1, 0, 0, 7, 1, 1, 1, 0, 32'h404);
        #1 chk("rt0_nostall", 32'(lu_stall), 0);
        drive(1, 1, 2, 0, 0, 0, 1, 1, 32'h408);
        step();
        drive(1, 9, 2, 7, 0, 1, 1, 0, 32'h40C);
        #1 chk("nort_nostall", 32'(lu_stall), 0);

        // Flush coincident with load-use
        drive(1, 1, 2, 0, 0, 0, 1, 1, 32'h500);
        step();
        drive(1, 2, 6, 7, 1, 1, 1, 0, 32'h504);
`ifdef IDEX_PERF_EN
        fl0 = flush_cnt;
        bub0 = bubble_cnt;
`endif
        flush = 1'b1;
        #1 chk("fs_stall", 32'(lu_stall), 1);
        step();
        flush = 1'b0;
        chk("fs_valid", 32'(ex_valid), 0);
        chk("fs_stall_clr", 32'(lu_stall), 0);
`ifdef IDEX_PERF_EN
        chk("fs_flush_cnt", 32'(flush_cnt), 32'(fl0) + 1);
        chk("fs_bubble_cnt", 32'(bubble_cnt), 32'(bub0));
`endif
        step();
        chk("fs_next_cap", ex_pc, 32'h504);

        // id_valid=0 loads a bubble
        drive(0, 3, 4, 5, 1, 1, 1, 0, 32'h600);
        step();
        chk("nv_bubble", 32'(ex_valid), 0);

`ifdef IDEX_PERF_EN
        flush = 1'b1;
        repeat (65540) step();
        chk("sat_flush", 32'(flush_cnt), 32'hFFFF);
        step();
        chk("sat_hold", 32'(flush_cnt), 32'hFFFF);
        flush = 1'b0;
`endif
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
